sm_mem_initiator: RTL

- Initiator (master) side of the valid/ready memory handshake used by the schoolMIPS busy-RAM responders.
- Sits between the CPU load/store stage and a data memory such as the delayed or the zero-wait RAM.
- Accepts one CPU access at a time, holds address and data stable on the bus, waits for the responder's ready, registers read data, and stalls the pipeline until completion.

---
 rtl/sm_mem_initiator.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sm_mem_initiator.sv
// Initiator side of the schoolMIPS valid/ready memory handshake: one CPU access at a time,
// bus fields held REQ..DONE. Optional WAIT-state abort is enabled by SM_MEM_INIT_TIMEOUT_EN.
module sm_mem_initiator #(
  parameter logic [7:0]  TIMEOUT  = 8'd64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rd,
  output logic        cpu_err,
  output logic [31:0] a,
  output logic        we,
  output logic [31:0] wd,
  output logic        valid,
  input  logic        ready,
  input  logic [31:0] rd,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Handshake: valid is high for exactly the REQ cycle; the first ready seen in a later
  // WAIT cycle completes the access (ready during REQ is the responder's idle-ready and is ignored).
  logic [1:0] state;
  logic [1:0] state_next;
  logic       complete;
  logic       abort;

  assign complete = (state == S_WAIT) && ready;

`ifdef SM_MEM_INIT_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  assign abort = (state == S_WAIT) && !ready && (tmo_cnt == (TIMEOUT - 8'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_REQ) begin
        tmo_cnt <= 8'd0;
      end else if ((state == S_WAIT) && !ready) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (state == S_WAIT) begin
        err_q <= abort;
      end
    end
  end

  assign cpu_err = (state == S_DONE) && err_q;
`else
  logic unused_params;

  assign unused_params = ^{TIMEOUT, ERR_DATA};
  assign abort         = 1'b0;
  assign cpu_err       = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cpu_req) state_next = S_REQ;
      S_REQ:   state_next = S_WAIT;
      S_WAIT:  if (complete || abort) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus fields latch only in IDLE so they stay constant from REQ through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a      <= 32'd0;
      we     <= 1'b0;
      wd     <= 32'd0;
      cpu_rd <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            a  <= cpu_a;
            we <= cpu_we;
            wd <= cpu_wd;
          end
        end
        S_WAIT: begin
          if (complete) begin
            if (!we) cpu_rd <= rd;
          end else if (abort) begin
            cpu_rd <= ERR_DATA;
          end
        end
        S_DONE: we <= 1'b0;
        default: ;
      endcase
    end
  end

  assign valid     = (state == S_REQ);
  assign cpu_done  = (state == S_DONE);
  assign cpu_stall = ((state == S_IDLE) && cpu_req) || (state == S_REQ) || (state == S_WAIT);
  assign dbg_state = state;

endmodule
